// File: rtl/disp_pkg.sv
// Shared types, constants and parameter checks for the display scan controller.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // True when the digit count, slot length and dead-time form a usable scan.
    function automatic bit params_ok(input int unsigned ndig,
                                     input int unsigned prescale,
                                     input int unsigned dead);
        return (ndig >= 1) && (ndig <= 8) && (dead >= 1) && (prescale >= dead + 2);
    endfunction

    // Digit pointer width; a single-digit display still needs one bit.
    function automatic int unsigned dig_width(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Valid/ready load port carrying the packed digit nibbles into the scan controller.
interface disp_scan_ctrl_if #(
    parameter int unsigned NDIG = 4
);
    logic                ld_valid;
    logic                ld_ready;
    logic [4*NDIG-1:0]   ld_data;

    modport master (output ld_valid, output ld_data, input  ld_ready);
    modport slave  (input  ld_valid, input  ld_data, output ld_ready);
endinterface

// File: rtl/bcd2sevenseg.sv
// Hex nibble to seven-segment pattern {a,b,c,d,e,f,g}, 1 = lit; purely combinational.
module bcd2sevenseg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_c
);

    // Segment lookup, including A-F glyphs so raw hex values display sensibly.
    always_comb begin
        seg_c = 7'b0000000;
        case (digit_i)
            4'h0: seg_c = 7'b1111110;
            4'h1: seg_c = 7'b0110000;
            4'h2: seg_c = 7'b1101101;
            4'h3: seg_c = 7'b1111001;
            4'h4: seg_c = 7'b0110011;
            4'h5: seg_c = 7'b1011011;
            4'h6: seg_c = 7'b1011111;
            4'h7: seg_c = 7'b1110000;
            4'h8: seg_c = 7'b1111111;
            4'h9: seg_c = 7'b1111011;
            4'hA: seg_c = 7'b1110111;
            4'hB: seg_c = 7'b0011111;
            4'hC: seg_c = 7'b1001110;
            4'hD: seg_c = 7'b0111101;
            4'hE: seg_c = 7'b1001111;
            4'hF: seg_c = 7'b1000111;
            default: seg_c = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared decoder, per-slot dead-time,
// and a shadow/active value pair so a new load only takes effect at a frame boundary.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned DEAD     = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                lz_en_i,
    disp_scan_ctrl_if.slave     ld,
    output logic [6:0]          seg_o,
    output logic [NDIG-1:0]     an_n_o,
    output logic                frame_tick_o
);

    localparam int unsigned CNT_W  = $clog2(PRESCALE);
    localparam int unsigned DIG_W  = dig_width(NDIG);
    localparam int unsigned DATA_W = 4 * NDIG;

    if (!params_ok(NDIG, PRESCALE, DEAD)) begin : g_param_err
        $error("disp_scan_ctrl: illegal NDIG/PRESCALE/DEAD combination");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   active_q, active_d;
    logic                pending_q, pending_d;
    logic                ld_ready_q, ld_ready_d;
    logic [6:0]          seg_q, seg_d;
    logic [NDIG-1:0]     an_n_q, an_n_d;
    logic                frame_tick_q, frame_tick_d;

    logic                wrap;
    logic                accept;
    logic                commit;
    logic [3:0]          nib;
    logic [6:0]          seg_dec;
    logic [NDIG-1:0]     lz_mask;
    logic                suppress;

    // Scan sequencer: IDLE -> BLANK (dead-time) -> DRIVE, stepping the digit each slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        wrap    = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dig_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    dig_d   = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DEAD - 1)) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        wrap    = (dig_q == DIG_W'(NDIG - 1));
                        dig_d   = wrap ? '0 : dig_q + DIG_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dig_d   = '0;
                end
            endcase
        end
    end

    // Per-digit leading-zero flags: digit k is blankable when nibbles k..NDIG-1 are all zero.
    always_comb begin
        lz_mask = '0;
        for (int k = 1; k < int'(NDIG); k++) begin
            lz_mask[k] = 1'b1;
            for (int j = k; j < int'(NDIG); j++) begin
                if (active_q[4*j +: 4] != 4'h0) begin
                    lz_mask[k] = 1'b0;
                end
            end
        end
    end

    // Nibble mux on the next-state digit so seg/an_n register together with the state.
    always_comb begin
        nib      = active_q[4*int'(dig_d) +: 4];
        suppress = lz_en_i && lz_mask[dig_d];
    end

    bcd2sevenseg u_dec (
        .digit_i (nib),
        .seg_c   (seg_dec)
    );

    // Load handshake, frame-boundary commit and next registered pin values.
    always_comb begin
        accept       = ld.ld_valid && ld_ready_q;
        commit       = pending_q && (wrap || (state_q == ST_IDLE));
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        seg_d        = SEG_OFF;
        an_n_d       = '1;
        frame_tick_d = wrap;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = ld.ld_data;
            pending_d = 1'b1;
        end
        ld_ready_d = !pending_d;
        if ((state_d == ST_DRIVE) && !suppress) begin
            seg_d  = seg_dec;
            an_n_d = ~(NDIG'(1) << dig_d);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dig_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            ld_ready_q   <= 1'b1;
            seg_q        <= SEG_OFF;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            ld_ready_q   <= ld_ready_d;
            seg_q        <= seg_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ld.ld_ready   = ld_ready_q;
    assign seg_o         = seg_q;
    assign an_n_o        = an_n_q;
    assign frame_tick_o  = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl with NDIG=4, PRESCALE=8, DEAD=2.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        lz_en;
    logic [6:0]  seg;
    logic [3:0]  an_n;
    logic        frame_tick;

    int total;
    int bad;

    disp_scan_ctrl_if #(.NDIG(4)) ld_if ();

    disp_scan_ctrl #(
        .NDIG     (4),
        .PRESCALE (8),
        .DEAD     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .lz_en_i      (lz_en),
        .ld           (ld_if),
        .seg_o        (seg),
        .an_n_o       (an_n),
        .frame_tick_o (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written glyph table {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Expected anodes in the cycle after the k-th edge since en rose (32-cycle frame).
    function automatic logic [3:0] exp_an(input logic [15:0] v, input bit lz, input int k);
        int p;
        int slot;
        int c;
        p    = (k - 1) % 32;
        slot = p / 8;
        c    = p % 8;
        if (c < 2) return 4'b1111;
        if (lz && slot != 0 && (v >> (4 * slot)) == 16'h0) return 4'b1111;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input bit lz, input int k);
        int p;
        int slot;
        int c;
        p    = (k - 1) % 32;
        slot = p / 8;
        c    = p % 8;
        if (c < 2) return 7'b0000000;
        if (lz && slot != 0 && (v >> (4 * slot)) == 16'h0) return 7'b0000000;
        return seg_of(v[4*slot +: 4]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Park in IDLE, load a value, and let the IDLE commit take it.
    task automatic load_idle(input logic [15:0] v);
        en = 1'b0;
        tick();
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = v;
        tick();
        ld_if.ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        en             = 1'b1;
        lz_en          = 1'b0;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (an_n !== 4'b1111 || seg !== 7'b0 || ld_if.ld_ready !== 1'b1 || frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got an=%b seg=%b rdy=%b ft=%b exp an=1111 seg=0000000 rdy=1 ft=0",
                         i, an_n, seg, ld_if.ld_ready, frame_tick);
            end
        end
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        total++;
        if (ld_if.ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_accept got rdy=%b exp 0", ld_if.ld_ready);
        end
        ld_if.ld_valid = 1'b0;
        tick();
        total++;
        if (ld_if.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle_commit got rdy=%b exp 1", ld_if.ld_ready);
        end
        en = 1'b1;
        repeat (3) tick();
        total++;
        if (an_n !== 4'b1110 || seg !== 7'b1111011) begin
            bad++;
            $display("FAIL reset_value_shown got an=%b seg=%b exp an=1110 seg=1111011", an_n, seg);
        end
    endtask

    task automatic test_basic_scan();
        logic [3:0] ea;
        logic [6:0] es;
        logic       et;
        load_idle(16'h1234);
        en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            ea = exp_an(16'h1234, 1'b0, k);
            es = exp_seg(16'h1234, 1'b0, k);
            et = (((k - 1) % 32) == 0) && (k > 1);
            total++;
            if (an_n !== ea || seg !== es || frame_tick !== et || ld_if.ld_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_scan k=%0d got an=%b seg=%b ft=%b rdy=%b exp an=%b seg=%b ft=%b rdy=1",
                         k, an_n, seg, frame_tick, ld_if.ld_ready, ea, es, et);
            end
        end
    endtask

    task automatic test_mid_frame_load();
        logic [15:0] v;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        er;
        load_idle(16'h1234);
        en            = 1'b1;
        ld_if.ld_data = 16'hABCD;
        for (int k = 1; k <= 64; k++) begin
            ld_if.ld_valid = (k == 10);
            tick();
            v  = (k <= 32) ? 16'h1234 : 16'hABCD;
            ea = exp_an(v, 1'b0, k);
            es = exp_seg(v, 1'b0, k);
            er = !((k >= 10) && (k <= 32));
            total++;
            if (an_n !== ea || seg !== es || ld_if.ld_ready !== er) begin
                bad++;
                $display("FAIL mid_frame_load k=%0d got an=%b seg=%b rdy=%b exp an=%b seg=%b rdy=%b",
                         k, an_n, seg, ld_if.ld_ready, ea, es, er);
            end
        end
        ld_if.ld_valid = 1'b0;
    endtask

    task automatic test_wrap_collision();
        logic [15:0] v;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        er;
        load_idle(16'h1234);
        en            = 1'b1;
        ld_if.ld_data = 16'h5678;
        for (int k = 1; k <= 96; k++) begin
            ld_if.ld_valid = (k == 33);
            tick();
            v  = (k <= 64) ? 16'h1234 : 16'h5678;
            ea = exp_an(v, 1'b0, k);
            es = exp_seg(v, 1'b0, k);
            er = !((k >= 33) && (k <= 64));
            total++;
            if (an_n !== ea || seg !== es || ld_if.ld_ready !== er) begin
                bad++;
                $display("FAIL wrap_collision k=%0d got an=%b seg=%b rdy=%b exp an=%b seg=%b rdy=%b",
                         k, an_n, seg, ld_if.ld_ready, ea, es, er);
            end
        end
        ld_if.ld_valid = 1'b0;
    endtask

    task automatic test_leading_zeros();
        logic [15:0] vals [2];
        logic [3:0]  ea;
        logic [6:0]  es;
        vals[0] = 16'h0070;
        vals[1] = 16'h0000;
        lz_en   = 1'b1;
        for (int t = 0; t < 2; t++) begin
            load_idle(vals[t]);
            en = 1'b1;
            for (int k = 1; k <= 32; k++) begin
                tick();
                ea = exp_an(vals[t], 1'b1, k);
                es = exp_seg(vals[t], 1'b1, k);
                total++;
                if (an_n !== ea || seg !== es) begin
                    bad++;
                    $display("FAIL leading_zeros v=%h k=%0d got an=%b seg=%b exp an=%b seg=%b",
                             vals[t], k, an_n, seg, ea, es);
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [3:0] ea;
        logic [6:0] es;
        load_idle(16'h1234);
        en = 1'b1;
        repeat (22) tick();
        total++;
        if (an_n !== 4'b1011 || seg !== 7'b1101101) begin
            bad++;
            $display("FAIL en_drop_pre got an=%b seg=%b exp an=1011 seg=1101101", an_n, seg);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (an_n !== 4'b1111 || seg !== 7'b0 || frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL en_drop_dark cyc=%0d got an=%b seg=%b ft=%b exp an=1111 seg=0000000 ft=0",
                         i, an_n, seg, frame_tick);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ea = exp_an(16'h1234, 1'b0, k);
            es = exp_seg(16'h1234, 1'b0, k);
            total++;
            if (an_n !== ea || seg !== es) begin
                bad++;
                $display("FAIL en_restart k=%0d got an=%b seg=%b exp an=%b seg=%b", k, an_n, seg, ea, es);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        en             = 1'b0;
        lz_en          = 1'b0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 16'h0;
        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_wrap_collision();
        test_leading_zeros();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the microcomputer's multi-digit seven-segment display. It shares one `bcd2sevenseg` decoder across `NDIG` digits, stepping a digit pointer on a prescaled tick and inserting a blanking dead-time between digits to prevent ghosting. It holds the displayed value in an active register that updates only at frame boundaries through a valid/ready load port, so the display never tears mid-frame. It sits between the CPU's output-port register and the board's segment/anode pins.

## Interface
- `NDIG`, 4: number of digits, 1..8; `ld_data` width is 4*NDIG
- `PRESCALE`, 1000: clocks per digit slot; must be ≥ DEAD+2
- `DEAD`, 50: blanked clocks at the start of each slot; must be ≥ 1
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  scan enable; 0 forces IDLE with display dark
- `lz_en`  in  1  leading-zero suppression enable
- `ld_valid`  in  1  load request
- `ld_ready`  out  1  controller can accept a load
- `ld_data`  in  4*NDIG  nibble k = digit k; digit 0 is least significant
- `seg`  out  7  segments {a,b,c,d,e,f,g}, 1 = lit
- `an_n`  out  NDIG  digit enables, active-low
- `frame_tick`  out  1  one-cycle pulse at each frame wrap

## Operation
- Reset values: state=IDLE, cnt=0, dig=0, shadow=0, active=0, pending=0, `ld_ready`=1, `an_n`=all 1, `seg`=0, `frame_tick`=0. Reset overrides everything, including mid-frame.
- Load handshake: accept when `ld_valid && ld_ready`. On accept: shadow ← `ld_data`, pending ← 1. `ld_ready` = !pending (registered).
- Commit: if pending is set before the edge, active ← shadow and pending ← 0 on either of these edges:
  - a frame wrap edge;
  - any edge while in IDLE.
- A load accepted on the frame-wrap edge itself is committed at the next wrap, not the current one.
- States:
  - IDLE: entered when `en`=0. Next edge with `en`=1 → BLANK with cnt=0, dig=0.
  - BLANK: cnt 0..DEAD-1. At cnt=DEAD-1 → DRIVE.
  - DRIVE: cnt DEAD..PRESCALE-1. At cnt=PRESCALE-1: cnt ← 0, dig ← dig+1 (wraps NDIG-1→0), → BLANK.
  - `en`=0 in any state → IDLE on next edge; cnt and dig clear.
- Frame wrap: the DRIVE→BLANK edge with dig=NDIG-1. `frame_tick`=1 for the following cycle.
- Digit suppression (`lz_en`=1): digit k is suppressed if k≠0 and nibbles k..NDIG-1 of active are all zero. Digit 0 is never suppressed.
- Outputs in BLANK and IDLE: `an_n`=all 1, `seg`=0.
- Outputs in DRIVE: `an_n[dig]`=0 and `seg`=decode(active nibble dig), unless the digit is suppressed. A suppressed digit drives `an_n`=all 1 and `seg`=0.

## Timing
- All outputs are registered. `seg` and `an_n` change on the same edge the state register enters the corresponding state; there is no extra pipeline skew between them.
- Digit lit for PRESCALE-DEAD cycles per slot. Frame period = NDIG*PRESCALE cycles.
- Load-to-display latency:
  - in IDLE: 2 edges (accept, commit);
  - while scanning: until the next frame wrap, then visible from that digit's DRIVE entry.
- `ld_ready` is low from the edge after accept through the commit edge; it is high again in the cycle after commit.
- `en` drop: dark on the next edge. `en` rise: first DRIVE starts DEAD+1 edges later, at dig=0.

## Structure
- Shared package `disp_pkg`:
  - state encoding constants ST_IDLE, ST_BLANK, ST_DRIVE;
  - `SEG_OFF` = 7'b0000000;
  - parameter-legality check function.
- One sub-module: the existing `bcd2sevenseg`, instantiated once. It is fed by the nibble mux on the next-state digit index.
- cnt width = $clog2(PRESCALE); dig width = max(1, $clog2(NDIG)).

## Test plan
All scenarios use NDIG=4, PRESCALE=8, DEAD=2 (frame = 32 cycles).
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 and `ld_valid`=1 → `an_n`=4'b1111, `seg`=0, `ld_ready`=1, no accept. After release, the first accept occurs only on the following edge.
- Basic scan: `en`=0, load 16'h1234, then `en`=1 →
  - slot 0: 2 dark cycles, then 6 cycles with `an_n`=1110, `seg`=0110011;
  - slot 1: `an_n`=1101, `seg`=1111001;
  - `frame_tick` pulses every 32 cycles.
- Mid-frame load: with 16'h1234 displayed, load 16'hABCD during dig=1 → `ld_ready`=0 until the wrap; digits 2 and 3 still show 2 and 1. The next frame's digit 0 shows `seg`=0111101.
- Wrap collision: load accepted on the exact frame-wrap edge → the current frame keeps the old value; the new value is displayed from the following frame; `ld_ready` stays low for the full 32 cycles.
- Leading zeros, `lz_en`=1:
  - value 16'h0070 → slots 3 and 2 stay fully dark; slot 1 shows `seg`=1110000; slot 0 shows `seg`=1111110;
  - value 16'h0000 → only slot 0 lights, with `seg`=1111110.
- Enable drop: `en`=0 at dig=2, cnt=5 → next cycle `an_n`=1111, `seg`=0. Re-assert `en` → scan restarts at dig=0 with 2 blank cycles.
